// File: rtl/dm_dmi_regs.sv
// RISC-V Debug Module register block: DMI slave decode, hart run control and
// Access Register abstract commands into a single hart's GPR file.
module dm_dmi_regs #(
  parameter int unsigned XLEN       = 64,
  parameter logic [3:0]  DM_VERSION = 4'd2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dmi_rstn_i,
  input  logic            dmi_req_valid_i,
  output logic            dmi_req_ready_o,
  input  logic [6:0]      dmi_req_addr_i,
  input  logic            dmi_req_op_i,
  input  logic [31:0]     dmi_req_data_i,
  output logic            dmi_resp_valid_o,
  output logic [31:0]     dmi_resp_data_o,
  output logic            dmi_resp_err_o,
  output logic            ndmreset_o,
  output logic            halt_req_o,
  output logic            resume_req_o,
  input  logic            hart_halted_i,
  input  logic            hart_resumeack_i,
  output logic            hart_reg_req_o,
  output logic            hart_reg_we_o,
  output logic [4:0]      hart_reg_addr_o,
  output logic [XLEN-1:0] hart_reg_wdata_o,
  input  logic [XLEN-1:0] hart_reg_rdata_i,
  input  logic            hart_reg_ack_i
);

  typedef enum logic {DMI_IDLE, DMI_RESP} dmi_state_e;
  typedef enum logic {A_IDLE, A_REQ} abs_state_e;

  dmi_state_e dmi_state_q, dmi_state_d;
  abs_state_e abs_state_q, abs_state_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic        dmactive_q, dmactive_d, haltreq_q, haltreq_d, ndmreset_q, ndmreset_d;
  logic        resume_req_q, resume_req_d, resumeack_q, resumeack_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [4:0]  cmd_regno_q, cmd_regno_d;
  logic        cmd_write_q, cmd_write_d, cmd_is64_q, cmd_is64_d;

  logic        accept, busy, is_data, busy_viol, cmd_bad;
  logic [31:0] rdata;
  logic [63:0] rdata64, wdata64;

  assign busy    = (abs_state_q == A_REQ);
  assign rdata64 = 64'(hart_reg_rdata_i);
  assign wdata64 = cmd_is64_q ? {data1_q, data0_q} : {32'd0, data0_q};

  // A DTM-side DMI reset blocks acceptance and suppresses a pending response.
  assign dmi_req_ready_o  = (dmi_state_q == DMI_IDLE) && dmi_rstn_i;
  assign dmi_resp_valid_o = (dmi_state_q == DMI_RESP) && dmi_rstn_i;
  assign dmi_resp_data_o  = dmi_resp_valid_o ? resp_data_q : '0;
  assign dmi_resp_err_o   = dmi_resp_valid_o && resp_err_q;

  assign ndmreset_o       = ndmreset_q;
  assign halt_req_o       = haltreq_q;
  assign resume_req_o     = resume_req_q;
  assign hart_reg_req_o   = busy;
  assign hart_reg_we_o    = busy && cmd_write_q;
  assign hart_reg_addr_o  = busy ? cmd_regno_q : '0;
  assign hart_reg_wdata_o = busy ? wdata64[XLEN-1:0] : '0;

  assign cmd_bad = (dmi_req_data_i[31:24] != 8'd0) ||
                   (dmi_req_data_i[22:20] != 3'd2 && dmi_req_data_i[22:20] != 3'd3) ||
                   (dmi_req_data_i[22:20] == 3'd3 && XLEN == 32) ||
                   (dmi_req_data_i[17] &&
                    (dmi_req_data_i[15:0] < 16'h1000 || dmi_req_data_i[15:0] > 16'h101F));

  always_comb begin
    dmi_state_d  = dmi_state_q;
    abs_state_d  = abs_state_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    dmactive_d   = dmactive_q;
    haltreq_d    = haltreq_q;
    ndmreset_d   = ndmreset_q;
    resume_req_d = resume_req_q;
    resumeack_d  = resumeack_q;
    cmderr_d     = cmderr_q;
    cmd_regno_d  = cmd_regno_q;
    cmd_write_d  = cmd_write_q;
    cmd_is64_d   = cmd_is64_q;
    rdata        = '0;

    accept    = dmi_req_valid_i && dmi_req_ready_o;
    is_data   = (dmi_req_addr_i == 7'h04) || (dmi_req_addr_i == 7'h05);
    busy_viol = busy && (is_data || (dmi_req_op_i &&
                (dmi_req_addr_i == 7'h16 || dmi_req_addr_i == 7'h17)));

    if (resume_req_q && hart_resumeack_i) begin
      resume_req_d = 1'b0;
      resumeack_d  = 1'b1;
    end

    if (busy && hart_reg_ack_i) begin
      if (!cmd_write_q) begin
        data0_d = rdata64[31:0];
        if (cmd_is64_q) data1_d = rdata64[63:32];
      end
      abs_state_d = A_IDLE;
    end

    case (dmi_req_addr_i)
      7'h04:   rdata = data0_q;
      7'h05:   rdata = (XLEN == 64) ? data1_q : '0;
      7'h10:   rdata = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
      7'h11:   rdata = {14'd0, resumeack_q, resumeack_q, 4'd0, !hart_halted_i, !hart_halted_i,
                        hart_halted_i, hart_halted_i, 1'b1, 3'd0, DM_VERSION};
      7'h16:   rdata = {19'd0, busy, 1'b0, cmderr_q, 4'd0, 4'd2};
      default: rdata = '0;
    endcase

    dmi_state_d = accept ? DMI_RESP : DMI_IDLE;
    if (accept) begin
      resp_err_d  = busy_viol;
      resp_data_d = (dmi_req_op_i || busy_viol) ? '0 : rdata;
      if (busy_viol) begin
        if (cmderr_q == 3'd0) cmderr_d = 3'd1;
      end else if (dmi_req_op_i) begin
        case (dmi_req_addr_i)
          7'h04: data0_d = dmi_req_data_i;
          7'h05: if (XLEN == 64) data1_d = dmi_req_data_i;
          7'h10: begin
            dmactive_d = dmi_req_data_i[0];
            ndmreset_d = dmi_req_data_i[1];
            haltreq_d  = dmi_req_data_i[31];
            if (dmi_req_data_i[30] && !dmi_req_data_i[31]) begin
              resumeack_d  = 1'b0;
              resume_req_d = 1'b1;
            end
          end
          7'h16: cmderr_d = cmderr_q & ~dmi_req_data_i[10:8];
          7'h17: begin
            if (cmderr_q == 3'd0) begin
              if (cmd_bad)                 cmderr_d = 3'd2;
              else if (!hart_halted_i)     cmderr_d = 3'd4;
              else if (dmi_req_data_i[17]) begin
                abs_state_d = A_REQ;
                cmd_regno_d = dmi_req_data_i[4:0];
                cmd_write_d = dmi_req_data_i[16];
                cmd_is64_d  = (dmi_req_data_i[22:20] == 3'd3);
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Clearing after all updates holds the DM at reset while dmactive is low.
    if (!dmactive_d) begin
      haltreq_d    = 1'b0;
      ndmreset_d   = 1'b0;
      resume_req_d = 1'b0;
      resumeack_d  = 1'b0;
      cmderr_d     = '0;
      abs_state_d  = A_IDLE;
      data0_d      = '0;
      data1_d      = '0;
      cmd_regno_d  = '0;
      cmd_write_d  = 1'b0;
      cmd_is64_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dmi_state_q  <= DMI_IDLE;
      abs_state_q  <= A_IDLE;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
      dmactive_q   <= 1'b0;
      haltreq_q    <= 1'b0;
      ndmreset_q   <= 1'b0;
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b0;
      cmderr_q     <= '0;
      cmd_regno_q  <= '0;
      cmd_write_q  <= 1'b0;
      cmd_is64_q   <= 1'b0;
    end else begin
      dmi_state_q  <= dmi_state_d;
      abs_state_q  <= abs_state_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      dmactive_q   <= dmactive_d;
      haltreq_q    <= haltreq_d;
      ndmreset_q   <= ndmreset_d;
      resume_req_q <= resume_req_d;
      resumeack_q  <= resumeack_d;
      cmderr_q     <= cmderr_d;
      cmd_regno_q  <= cmd_regno_d;
      cmd_write_q  <= cmd_write_d;
      cmd_is64_q   <= cmd_is64_d;
    end
  end

endmodule
